// File: rtl/tick_gen.sv
// tick_gen: bank of independent clock-enable dividers with glitch-free reconfiguration.
//
// Each channel counts enabled cycles modulo its divisor D. In pulse mode it emits a
// one-cycle pulse every D enabled cycles. In square mode it emits a wave that is high
// for ceil(D/2) cycles and low for floor(D/2) cycles. New {divisor, mode} settings are
// staged in a per-channel shadow register. They take effect only at a terminal count,
// or while the channel is disabled, so a period is never cut short.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   en        per-channel count enable
//   cfg_we    configuration write strobe (one cycle)
//   cfg_ch    target channel of the write
//   cfg_div   new divisor D (period in clk cycles), must be >= 2
//   cfg_mode  new mode: 0 = pulse, 1 = square
//   out       registered per-channel divided output
//   pend      per-channel flag: a shadow configuration is waiting to be applied
//   cfg_err   one-cycle pulse: the previous-cycle write was rejected
module tick_gen #(
  parameter int unsigned CH      = 4,
  parameter int unsigned CW      = 16,
  parameter int unsigned DEF_DIV = 500,
  localparam int unsigned CHW    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [CH-1:0]  en,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_div,
  input  logic           cfg_mode,
  output logic [CH-1:0]  out,
  output logic [CH-1:0]  pend,
  output logic           cfg_err
);

  localparam logic [CW-1:0] DefDiv = CW'(DEF_DIV);

  // Per-channel state
  logic [CW-1:0] div_q  [CH];
  logic [CW-1:0] div_d  [CH];
  logic [CW-1:0] cnt_q  [CH];
  logic [CW-1:0] cnt_d  [CH];
  logic [CW-1:0] sdiv_q [CH];
  logic [CW-1:0] sdiv_d [CH];
  logic [CH-1:0] mode_q, mode_d;
  logic [CH-1:0] smode_q, smode_d;
  logic [CH-1:0] pend_q, pend_d;
  logic [CH-1:0] out_q, out_d;
  logic          cfg_err_q, cfg_err_d;

  // Per-channel decode
  logic [CH-1:0] tc;
  logic [CH-1:0] apply;
  logic [CH-1:0] wr_sel;
  logic          ch_ok;
  logic          accept;

  // When CH fills the select field every encoding is a valid channel, and the range
  // compare would be constant, so it is left out in that case.
  if (CH == (1 << CHW)) begin : g_ch_full
    assign ch_ok = 1'b1;
  end else begin : g_ch_part
    assign ch_ok = (cfg_ch < CHW'(CH));
  end

  assign accept    = cfg_we & ch_ok & (cfg_div >= CW'(2));
  assign cfg_err_d = cfg_we & ~accept;

  always_comb begin
    for (int unsigned i = 0; i < CH; i++) begin
      tc[i]     = (cnt_q[i] == div_q[i] - CW'(1));
      // A pending configuration may land at a period boundary or while the channel is
      // disabled; either way the output never sees a truncated period.
      apply[i]  = pend_q[i] & (tc[i] | ~en[i]);
      wr_sel[i] = accept & (cfg_ch == CHW'(i));
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < CH; i++) begin
      // Counter
      cnt_d[i] = cnt_q[i];
      if (apply[i]) begin
        cnt_d[i] = '0;
      end else if (en[i]) begin
        cnt_d[i] = tc[i] ? '0 : cnt_q[i] + CW'(1);
      end

      // Active configuration loads from the shadow as it stood at the start of the cycle
      div_d[i]  = apply[i] ? sdiv_q[i]  : div_q[i];
      mode_d[i] = apply[i] ? smode_q[i] : mode_q[i];

      // Shadow: the last accepted write wins, even one arriving in the apply cycle
      sdiv_d[i]  = wr_sel[i] ? cfg_div  : sdiv_q[i];
      smode_d[i] = wr_sel[i] ? cfg_mode : smode_q[i];
      pend_d[i]  = wr_sel[i] | (pend_q[i] & ~apply[i]);

      // Output, computed from the configuration active in this cycle
      if (mode_q[i]) begin
        // High while cnt < ceil(D/2); extra bit keeps D+1 from overflowing
        out_d[i] = en[i] ? ({1'b0, cnt_q[i]} < (({1'b0, div_q[i]} + (CW+1)'(1)) >> 1))
                         : out_q[i];
      end else begin
        out_d[i] = en[i] & tc[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < CH; i++) begin
        div_q[i]  <= DefDiv;
        cnt_q[i]  <= '0;
        sdiv_q[i] <= DefDiv;
      end
      mode_q    <= '0;
      smode_q   <= '0;
      pend_q    <= '0;
      out_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < CH; i++) begin
        div_q[i]  <= div_d[i];
        cnt_q[i]  <= cnt_d[i];
        sdiv_q[i] <= sdiv_d[i];
      end
      mode_q    <= mode_d;
      smode_q   <= smode_d;
      pend_q    <= pend_d;
      out_q     <= out_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign out     = out_q;
  assign pend    = pend_q;
  assign cfg_err = cfg_err_q;

endmodule
